matrix_deserialize: RTL

MATRIX_DESERIALIZE -- requirements
Module: matrix_deserialize

---
 rtl/matrix_deserialize.sv | 130 +++++++++++++
 1 files changed

// File: rtl/matrix_deserialize.sv
// Collects a row-major stream of complex elements into one wide matrix beat.
// Optional framing checks on s_axis_tlast: define MATRIX_DESERIALIZE_TLAST_CHECK_EN.
module matrix_deserialize #(
  parameter int MAT_WIDTH    = 4,
  parameter int MAT_HEIGHT   = 4,
  parameter int ELEMENT_SIZE = 32
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [ELEMENT_SIZE-1:0]                   s_axis_tdata,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  input  logic                                      s_axis_tuser,
  output logic                                      s_axis_tready,
  output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic                                      m_axis_tuser,
  output logic                                      err_tlast
);

  localparam int N     = MAT_WIDTH * MAT_HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t                        state_r;
  state_t                        state_next_s;
  logic [IDX_W-1:0]              idx_r;
  logic [IDX_W-1:0]              idx_next_s;
  logic [N*ELEMENT_SIZE-1:0]     data_r;
  logic                          tuser_r;
  logic                          err_r;
  logic                          accept_s;
  logic                          last_s;
  logic                          frame_err_s;

`ifndef MATRIX_DESERIALIZE_TLAST_CHECK_EN
  logic                          unused_tlast_s;
  assign unused_tlast_s = s_axis_tlast;
`endif

  // All outputs come straight from registers.
  assign s_axis_tready = (state_r == COLLECT);
  assign m_axis_tvalid = (state_r == OUTPUT);
  assign m_axis_tdata  = data_r;
  assign m_axis_tlast  = 1'b1;
  assign m_axis_tuser  = tuser_r;
  assign err_tlast     = err_r;

  // Next-state, index advance and framing-error detection.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      COLLECT: begin
        accept_s = s_axis_tvalid;
        if (s_axis_tvalid) begin
`ifdef MATRIX_DESERIALIZE_TLAST_CHECK_EN
          // Early tlast closes the matrix; missing tlast on the final slot is flagged only.
          last_s      = (idx_r == IDX_LAST) || s_axis_tlast;
          frame_err_s = (idx_r == IDX_LAST) ? ~s_axis_tlast : s_axis_tlast;
`else
          last_s      = (idx_r == IDX_LAST);
          frame_err_s = 1'b0;
`endif
          if (last_s) begin
            state_next_s = OUTPUT;
            idx_next_s   = IDX_ZERO;
          end else begin
            state_next_s = COLLECT;
            idx_next_s   = idx_r + IDX_ONE;
          end
        end else begin
          state_next_s = COLLECT;
          idx_next_s   = idx_r;
        end
      end
      OUTPUT: begin
        if (m_axis_tready) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = OUTPUT;
        end
      end
      default: begin
        state_next_s = COLLECT;
        idx_next_s   = IDX_ZERO;
      end
    endcase
  end

  // State, slot buffer, sideband capture and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= COLLECT;
      idx_r   <= IDX_ZERO;
      data_r  <= {(N*ELEMENT_SIZE){1'b0}};
      tuser_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      if (accept_s) begin
        data_r[idx_r*ELEMENT_SIZE +: ELEMENT_SIZE] <= s_axis_tdata;
        if (idx_r == IDX_ZERO) begin
          tuser_r <= s_axis_tuser;
        end
      end else if ((state_r == OUTPUT) && m_axis_tready) begin
        // Clearing on handshake keeps unwritten slots zero after an early tlast.
        data_r  <= {(N*ELEMENT_SIZE){1'b0}};
        tuser_r <= 1'b0;
      end
      if (frame_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule
